wb_except_ctrl: RTL and testbench
=================================

Name: wb_except_ctrl

Overview:
- Writeback-stage exception/commit controller that sits directly upstream of the CP0 register file.
- Takes the retiring WB instruction plus its exception flags, samples and synchronises hardware interrupts, and prioritises everything into one exception per cycle.
- Drives CP0's write-side controls: wb_ex, eret_flush, mtc0_we, cp0_addr, cp0_wdata, plus EPC/BadVAddr/ExcCode/BD.
- Issues a pipeline flush with a fetch-redirect handshake, and squashes WB commits until that handshake completes.

Parameters:
- HW_INT, 6, number of hardware interrupt lines.
- EX_ENTRY, 32'hbfc00380, redirect PC for every exception (Status.BEV fixed at 1).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ws_valid  in  1  WB holds a valid instruction this cycle
- ws_pc  in  32  PC of the WB instruction
- ws_bd  in  1  WB instruction is in a branch delay slot
- ws_exc  in  7  flags {adel_if, ri, ov, sys, brk, adel_ld, ades}
- ws_badvaddr  in  32  faulting data address (adel_ld/ades)
- ws_eret  in  1  WB instruction is ERET
- ws_mtc0  in  1  WB instruction is MTC0
- ws_cp0_addr  in  8  {rd[4:0], sel[2:0]}
- ws_rt_value  in  32  MTC0 source data
- status_ie  in  1  CP0 Status.IE
- status_exl  in  1  CP0 Status.EXL
- status_im  in  8  CP0 Status.IM
- cause_ip_sw  in  2  CP0 Cause.IP[1:0]
- epc_value  in  32  current CP0 EPC (ERET target)
- hw_int  in  HW_INT  asynchronous interrupt lines
- wb_ex  out  1  exception taken this cycle
- wb_excode  out  5  Cause.ExcCode
- wb_bd  out  1  BD for Cause
- wb_epc  out  32  EPC value to write
- wb_badvaddr  out  32  BadVAddr value to write
- eret_flush  out  1  ERET committed this cycle
- mtc0_we  out  1  CP0 write enable
- cp0_addr  out  8  CP0 write address
- cp0_wdata  out  32  CP0 write data
- cause_ip_hw  out  HW_INT  synchronised interrupt lines, to Cause.IP[7:2]
- ws_commit  out  1  WB instruction architecturally retires
- flush_valid  out  1  redirect request to fetch
- flush_pc  out  32  redirect target
- flush_ready  in  1  fetch accepts the redirect

Behaviour:
- Reset (resetn low, async):
  - state=IDLE.
  - All outputs 0, except flush_pc=EX_ENTRY.
  - Synchroniser flops cleared.
- Interrupt sync:
  - hw_int passes through a 2-flop synchroniser to cause_ip_hw (2-cycle latency).
  - int_pend = status_ie & ~status_exl & |({cause_ip_hw, cause_ip_sw} & status_im).
- Priority (highest first): int, adel_if(4), ri(10), ov(12), sys(8), brk(9), adel_ld(4), ades(5). Interrupt ExcCode is 0.
- Interrupts attach only to a valid WB instruction.
- wb_epc = ws_bd ? ws_pc-4 : ws_pc.
- wb_badvaddr = adel_if ? ws_pc : ws_badvaddr; it is 0 for any other ExcCode.
- All outputs are combinational from WB inputs and gated by state==IDLE. They are single-cycle pulses aligned with the WB instruction.
- IDLE state:
  - Exception pending and ws_valid: wb_ex=1, ws_commit=0, flush_pc=EX_ENTRY, go to FLUSH.
  - Else ERET and ws_valid: eret_flush=1, ws_commit=1, flush_pc=epc_value, go to FLUSH.
  - Else MTC0 and ws_valid: mtc0_we=1, cp0_addr=ws_cp0_addr, cp0_wdata=ws_rt_value, ws_commit=1, stay in IDLE.
  - Else ws_commit=ws_valid.
- FLUSH state:
  - flush_valid=1; flush_pc is held stable by a register captured on entry.
  - wb_ex, eret_flush, mtc0_we and ws_commit are forced to 0, squashing in-flight WB instructions.
  - flush_valid & flush_ready: go to IDLE next cycle.
  - flush_valid stays high until accepted and never drops without a handshake.
- An exception on an ERET/MTC0 instruction takes priority: no eret_flush, no mtc0_we.
- A flush_ready already high on FLUSH entry completes in 1 cycle (minimum 1-cycle FLUSH).
- resetn asserted in FLUSH: return to IDLE immediately and drop flush_valid.
- Interrupt lines changing during FLUSH: sampled but not acted on until IDLE.

Decomposition:
- Shared package/header holds:
  - ExcCode constants (EX_INT=0, EX_ADEL=4, EX_ADES=5, EX_SYS=8, EX_BP=9, EX_RI=10, EX_OV=12).
  - CP0 address constants ({rd,sel}: STATUS=8'h60, CAUSE=8'h68, EPC=8'h70, BADVADDR=8'h40).
  - EX_ENTRY.
  - The ws_exc bit-index constants.
- One sub-module: int_sync (parameterised width, 2-flop synchroniser, async active-low reset).

Test Plan:
- ws_valid=1, ws_exc=ov, ws_bd=1, ws_pc=32'h1000 -> wb_ex=1, wb_excode=12, wb_bd=1, wb_epc=32'h0ffc, ws_commit=0; next cycle flush_valid=1, flush_pc=32'hbfc00380.
- ws_exc={adel_if,ri} both set, ws_pc=32'h1003 -> wb_excode=4, wb_badvaddr=32'h1003.
- ws_eret=1, epc_value=32'h2000, flush_ready held 0 for 3 cycles -> eret_flush pulses once; flush_valid high for 4 cycles with flush_pc=32'h2000; ws_valid inputs during FLUSH produce ws_commit=0.
- hw_int[0] rises, status_ie=1, status_exl=0, status_im=8'h04, ws_valid=1 -> cause_ip_hw[0]=1 after 2 cycles, then wb_ex=1 with wb_excode=0; repeat with status_exl=1 -> no wb_ex.
- ws_mtc0=1, ws_cp0_addr=8'h60, ws_rt_value=32'h0000ff01 -> mtc0_we=1, cp0_addr=8'h60, cp0_wdata=32'h0000ff01 for exactly one cycle, ws_commit=1; same with ws_exc=ri -> mtc0_we=0, wb_ex=1.
- resetn dropped asynchronously mid-FLUSH -> flush_valid=0 and all outputs 0 immediately; after release, state is IDLE.

Source files
------------

// File: rtl/wb_except_ctrl_pkg.sv
// Shared constants for the writeback exception controller: MIPS ExcCodes,
// CP0 {rd,sel} addresses, the exception vector and ws_exc bit positions.
package wb_except_ctrl_pkg;

   localparam logic [4:0] EX_INT  = 5'd0;
   localparam logic [4:0] EX_ADEL = 5'd4;
   localparam logic [4:0] EX_ADES = 5'd5;
   localparam logic [4:0] EX_SYS  = 5'd8;
   localparam logic [4:0] EX_BP   = 5'd9;
   localparam logic [4:0] EX_RI   = 5'd10;
   localparam logic [4:0] EX_OV   = 5'd12;

   localparam logic [7:0] CP0_STATUS   = 8'h60;
   localparam logic [7:0] CP0_CAUSE    = 8'h68;
   localparam logic [7:0] CP0_EPC      = 8'h70;
   localparam logic [7:0] CP0_BADVADDR = 8'h40;

   localparam logic [31:0] EX_ENTRY = 32'hbfc00380;

   // ws_exc = {adel_if, ri, ov, sys, brk, adel_ld, ades}
   localparam int EXC_ADES    = 0;
   localparam int EXC_ADEL_LD = 1;
   localparam int EXC_BRK     = 2;
   localparam int EXC_SYS     = 3;
   localparam int EXC_OV      = 4;
   localparam int EXC_RI      = 5;
   localparam int EXC_ADEL_IF = 6;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_except_ctrl_int_sync.sv
// Two-flop synchroniser for the asynchronous hardware interrupt lines.
module int_sync #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/wb_except_ctrl.sv
// Writeback exception/commit controller feeding CP0: prioritises exceptions,
// drives CP0 write controls and holds a fetch redirect until it is accepted.
module wb_except_ctrl #(
   parameter int          HW_INT   = 6,
   parameter logic [31:0] EX_ENTRY = wb_except_ctrl_pkg::EX_ENTRY
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              ws_valid,
   input  logic [31:0]       ws_pc,
   input  logic              ws_bd,
   input  logic [6:0]        ws_exc,
   input  logic [31:0]       ws_badvaddr,
   input  logic              ws_eret,
   input  logic              ws_mtc0,
   input  logic [7:0]        ws_cp0_addr,
   input  logic [31:0]       ws_rt_value,
   input  logic              status_ie,
   input  logic              status_exl,
   input  logic [7:0]        status_im,
   input  logic [1:0]        cause_ip_sw,
   input  logic [31:0]       epc_value,
   input  logic [HW_INT-1:0] hw_int,
   output logic              wb_ex,
   output logic [4:0]        wb_excode,
   output logic              wb_bd,
   output logic [31:0]       wb_epc,
   output logic [31:0]       wb_badvaddr,
   output logic              eret_flush,
   output logic              mtc0_we,
   output logic [7:0]        cp0_addr,
   output logic [31:0]       cp0_wdata,
   output logic [HW_INT-1:0] cause_ip_hw,
   output logic              ws_commit,
   output logic              flush_valid,
   output logic [31:0]       flush_pc,
   input  logic              flush_ready
);
   import wb_except_ctrl_pkg::*;

   wb_state_e         state_q, state_d;
   logic [31:0]       flush_pc_q, flush_pc_d;
   logic [HW_INT+1:0] ip_all;
   logic              int_pend;
   logic              exc_hit;
   logic [4:0]        exc_code;
   logic [31:0]       exc_badvaddr;
   logic              active, ex_take, eret_take, mtc0_take;

   int_sync #(.WIDTH(HW_INT)) u_int_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (hw_int),
      .q      (cause_ip_hw)
   );

   assign ip_all   = {cause_ip_hw, cause_ip_sw};
   assign int_pend = status_ie & ~status_exl & (|(ip_all & status_im[HW_INT+1:0]));

   // Fixed-priority encoder; only address errors report a BadVAddr.
   always_comb begin
      exc_hit      = 1'b1;
      exc_code     = EX_INT;
      exc_badvaddr = '0;
      if (int_pend) begin
         exc_code = EX_INT;
      end else if (ws_exc[EXC_ADEL_IF]) begin
         exc_code     = EX_ADEL;
         exc_badvaddr = ws_pc;
      end else if (ws_exc[EXC_RI]) begin
         exc_code = EX_RI;
      end else if (ws_exc[EXC_OV]) begin
         exc_code = EX_OV;
      end else if (ws_exc[EXC_SYS]) begin
         exc_code = EX_SYS;
      end else if (ws_exc[EXC_BRK]) begin
         exc_code = EX_BP;
      end else if (ws_exc[EXC_ADEL_LD]) begin
         exc_code     = EX_ADEL;
         exc_badvaddr = ws_badvaddr;
      end else if (ws_exc[EXC_ADES]) begin
         exc_code     = EX_ADES;
         exc_badvaddr = ws_badvaddr;
      end else begin
         exc_hit = 1'b0;
      end
   end

   // resetn is folded in so outputs are quiet the moment reset asserts.
   assign active    = resetn & (state_q == ST_IDLE) & ws_valid;
   assign ex_take   = active & exc_hit;
   assign eret_take = active & ~exc_hit & ws_eret;
   assign mtc0_take = active & ~exc_hit & ~ws_eret & ws_mtc0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         flush_pc_q <= EX_ENTRY;
      end else begin
         state_q    <= state_d;
         flush_pc_q <= flush_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      flush_pc_d = flush_pc_q;
      case (state_q)
         ST_IDLE: begin
            if (ex_take) begin
               state_d    = ST_FLUSH;
               flush_pc_d = EX_ENTRY;
            end else if (eret_take) begin
               state_d    = ST_FLUSH;
               flush_pc_d = epc_value;
            end
         end
         ST_FLUSH: begin
            if (flush_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wb_ex       = ex_take;
      wb_excode   = '0;
      wb_bd       = 1'b0;
      wb_epc      = '0;
      wb_badvaddr = '0;
      eret_flush  = eret_take;
      mtc0_we     = mtc0_take;
      cp0_addr    = '0;
      cp0_wdata   = '0;
      ws_commit   = active & ~exc_hit;
      flush_valid = (state_q == ST_FLUSH);
      flush_pc    = EX_ENTRY;
      if (ex_take) begin
         wb_excode   = exc_code;
         wb_bd       = ws_bd;
         wb_epc      = ws_bd ? (ws_pc - 32'd4) : ws_pc;
         wb_badvaddr = exc_badvaddr;
      end
      if (mtc0_take) begin
         cp0_addr  = ws_cp0_addr;
         cp0_wdata = ws_rt_value;
      end
      if (state_q == ST_FLUSH) begin
         flush_pc = flush_pc_q;
      end else if (eret_take) begin
         flush_pc = epc_value;
      end
   end

endmodule

// File: tb/tb_wb_except_ctrl.sv
// Self-checking bench for wb_except_ctrl: directed vector table, hand-written
// flush/interrupt/reset sequences and randomised traffic against a reference model.
module tb_wb_except_ctrl;
   import wb_except_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ws_valid, ws_bd, ws_eret, ws_mtc0;
   logic [31:0] ws_pc, ws_badvaddr, ws_rt_value, epc_value;
   logic [6:0]  ws_exc;
   logic [7:0]  ws_cp0_addr, status_im;
   logic        status_ie, status_exl, flush_ready;
   logic [1:0]  cause_ip_sw;
   logic [5:0]  hw_int;
   logic        wb_ex, wb_bd, eret_flush, mtc0_we, ws_commit, flush_valid;
   logic [4:0]  wb_excode;
   logic [31:0] wb_epc, wb_badvaddr, cp0_wdata, flush_pc;
   logic [7:0]  cp0_addr;
   logic [5:0]  cause_ip_hw;

   always #5 clk = ~clk;

   wb_except_ctrl dut (
      .clk(clk), .resetn(resetn),
      .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_bd(ws_bd), .ws_exc(ws_exc),
      .ws_badvaddr(ws_badvaddr), .ws_eret(ws_eret), .ws_mtc0(ws_mtc0),
      .ws_cp0_addr(ws_cp0_addr), .ws_rt_value(ws_rt_value),
      .status_ie(status_ie), .status_exl(status_exl), .status_im(status_im),
      .cause_ip_sw(cause_ip_sw), .epc_value(epc_value), .hw_int(hw_int),
      .wb_ex(wb_ex), .wb_excode(wb_excode), .wb_bd(wb_bd), .wb_epc(wb_epc),
      .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush), .mtc0_we(mtc0_we),
      .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cause_ip_hw(cause_ip_hw),
      .ws_commit(ws_commit), .flush_valid(flush_valid), .flush_pc(flush_pc),
      .flush_ready(flush_ready)
   );

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic        bd;
      logic [6:0]  exc;
      logic [31:0] badv;
      logic        eret;
      logic        mtc0;
      logic [7:0]  addr;
      logic [31:0] rtv;
      logic        ie;
      logic        exl;
      logic [7:0]  im;
      logic [1:0]  ipsw;
      logic [31:0] epc;
      logic [5:0]  hw;
      logic        ready;
   } in_t;

   typedef struct {
      logic        ex;
      logic [4:0]  code;
      logic        bd;
      logic [31:0] epc;
      logic [31:0] badv;
      logic        eret;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [5:0]  ip;
      logic        commit;
      logic        fv;
      logic [31:0] fpc;
   } out_t;

   typedef struct {
      in_t         in;
      logic        ex;
      logic [4:0]  code;
      logic [31:0] epc;
      logic [31:0] badv;
      logic        we;
      logic        commit;
   } vec_t;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model state: redirect outstanding, its target, and the
   // interrupt lines seen at the last two clock edges.
   bit          m_flush;
   logic [31:0] m_fpc;
   logic [5:0]  ipq[$];

   function automatic in_t idleIn();
      in_t i;
      i.valid = 0; i.pc = '0; i.bd = 0; i.exc = '0; i.badv = '0;
      i.eret = 0; i.mtc0 = 0; i.addr = '0; i.rtv = '0;
      i.ie = 0; i.exl = 0; i.im = '0; i.ipsw = '0; i.epc = '0;
      i.hw = '0; i.ready = 1;
      return i;
   endfunction

   function automatic vec_t mkVec(logic v, logic [31:0] pc, logic bd, logic [6:0] exc,
                                  logic [31:0] badv, logic eret, logic mtc0,
                                  logic [7:0] addr, logic [31:0] rtv,
                                  logic ex, logic [4:0] code, logic [31:0] epc,
                                  logic [31:0] xbadv, logic we, logic commit);
      vec_t t;
      t.in = idleIn();
      t.in.valid = v; t.in.pc = pc; t.in.bd = bd; t.in.exc = exc; t.in.badv = badv;
      t.in.eret = eret; t.in.mtc0 = mtc0; t.in.addr = addr; t.in.rtv = rtv;
      t.ex = ex; t.code = code; t.epc = epc; t.badv = xbadv; t.we = we; t.commit = commit;
      return t;
   endfunction

   // Behaviour written straight from the priority list and ExcCode table.
   function automatic out_t refModel(in_t i);
      out_t o;
      int   codes[7];
      logic [7:0] ip_all;
      bit   hit;
      codes = '{4, 10, 12, 8, 9, 4, 5};
      o.ex = 0; o.code = '0; o.bd = 0; o.epc = '0; o.badv = '0; o.eret = 0;
      o.we = 0; o.addr = '0; o.wdata = '0; o.commit = 0; o.fv = 0;
      o.ip  = ipq[0];
      o.fpc = EX_ENTRY;
      if (m_flush) begin
         o.fv  = 1;
         o.fpc = m_fpc;
         return o;
      end
      if (!i.valid) return o;
      ip_all = {ipq[0], i.ipsw};
      hit = i.ie && !i.exl && ((ip_all & i.im) != 8'h00);
      if (!hit) begin
         for (int k = 0; k < 7; k++) begin
            if (!hit && i.exc[6-k]) begin
               hit    = 1;
               o.code = 5'(codes[k]);
               if (k == 0) o.badv = i.pc;
               else if (k >= 5) o.badv = i.badv;
            end
         end
      end
      if (hit) begin
         o.ex  = 1;
         o.bd  = i.bd;
         o.epc = i.bd ? i.pc - 32'd4 : i.pc;
      end else begin
         o.commit = 1;
         if (i.eret) begin
            o.eret = 1;
            o.fpc  = i.epc;
         end else if (i.mtc0) begin
            o.we    = 1;
            o.addr  = i.addr;
            o.wdata = i.rtv;
         end
      end
      return o;
   endfunction

   task automatic modelReset();
      m_flush = 0;
      m_fpc   = EX_ENTRY;
      ipq.delete();
      ipq.push_back(6'h0);
      ipq.push_back(6'h0);
   endtask

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input out_t e, input string n);
      checkField({n, ".wb_ex"},       32'(wb_ex),       32'(e.ex));
      checkField({n, ".wb_excode"},   32'(wb_excode),   32'(e.code));
      checkField({n, ".wb_bd"},       32'(wb_bd),       32'(e.bd));
      checkField({n, ".wb_epc"},      wb_epc,           e.epc);
      checkField({n, ".wb_badvaddr"}, wb_badvaddr,      e.badv);
      checkField({n, ".eret_flush"},  32'(eret_flush),  32'(e.eret));
      checkField({n, ".mtc0_we"},     32'(mtc0_we),     32'(e.we));
      checkField({n, ".cp0_addr"},    32'(cp0_addr),    32'(e.addr));
      checkField({n, ".cp0_wdata"},   cp0_wdata,        e.wdata);
      checkField({n, ".cause_ip_hw"}, 32'(cause_ip_hw), 32'(e.ip));
      checkField({n, ".ws_commit"},   32'(ws_commit),   32'(e.commit));
      checkField({n, ".flush_valid"}, 32'(flush_valid), 32'(e.fv));
      checkField({n, ".flush_pc"},    flush_pc,         e.fpc);
   endtask

   task automatic checkResetOutputs(input string n);
      out_t z;
      z.ex = 0; z.code = '0; z.bd = 0; z.epc = '0; z.badv = '0; z.eret = 0;
      z.we = 0; z.addr = '0; z.wdata = '0; z.ip = '0; z.commit = 0; z.fv = 0;
      z.fpc = EX_ENTRY;
      checkOutput(z, n);
   endtask

   task automatic driveInputs(input in_t i);
      ws_valid = i.valid; ws_pc = i.pc; ws_bd = i.bd; ws_exc = i.exc;
      ws_badvaddr = i.badv; ws_eret = i.eret; ws_mtc0 = i.mtc0;
      ws_cp0_addr = i.addr; ws_rt_value = i.rtv; status_ie = i.ie;
      status_exl = i.exl; status_im = i.im; cause_ip_sw = i.ipsw;
      epc_value = i.epc; hw_int = i.hw; flush_ready = i.ready;
   endtask

   task automatic applyStimulus(input in_t i, input string n, output out_t e);
      @(negedge clk);
      driveInputs(i);
      #1;
      e = refModel(i);
      checkOutput(e, n);
   endtask

   task automatic stepClock(input in_t i, input out_t e);
      @(posedge clk);
      if (m_flush) begin
         if (i.ready) m_flush = 0;
      end else if (e.ex || e.eret) begin
         m_flush = 1;
         m_fpc   = e.fpc;
      end
      ipq.push_back(i.hw);
      void'(ipq.pop_front());
   endtask

   task automatic runCycle(input in_t i, input string n);
      out_t e;
      applyStimulus(i, n, e);
      stepClock(i, e);
   endtask

   vec_t  vecs[13];
   in_t   cur, idl;
   out_t  exp_o;
   int    fv_count, eret_count;
   logic [7:0] addrs[4];

   initial begin
      addrs = '{CP0_STATUS, CP0_CAUSE, CP0_EPC, CP0_BADVADDR};
      vecs[0]  = mkVec(1, 32'h1000, 1, 7'b0010000, 32'h0,        0, 0, 8'h0, 32'h0,       1, 12, 32'h0ffc, 32'h0,        0, 0);
      vecs[1]  = mkVec(1, 32'h1003, 0, 7'b1100000, 32'h55,       0, 0, 8'h0, 32'h0,       1, 4,  32'h1003, 32'h1003,     0, 0);
      vecs[2]  = mkVec(1, 32'h2000, 0, 7'b0000010, 32'hdead0001, 0, 0, 8'h0, 32'h0,       1, 4,  32'h2000, 32'hdead0001, 0, 0);
      vecs[3]  = mkVec(1, 32'h2004, 1, 7'b0000001, 32'h12340002, 0, 0, 8'h0, 32'h0,       1, 5,  32'h2000, 32'h12340002, 0, 0);
      vecs[4]  = mkVec(1, 32'h3000, 0, 7'b0001000, 32'hffff,     0, 0, 8'h0, 32'h0,       1, 8,  32'h3000, 32'h0,        0, 0);
      vecs[5]  = mkVec(1, 32'h3004, 0, 7'b0000101, 32'h9,        0, 0, 8'h0, 32'h0,       1, 9,  32'h3004, 32'h0,        0, 0);
      vecs[6]  = mkVec(1, 32'h3008, 0, 7'b0110000, 32'h0,        0, 0, 8'h0, 32'h0,       1, 10, 32'h3008, 32'h0,        0, 0);
      vecs[7]  = mkVec(1, 32'h4000, 0, 7'b0000000, 32'h0,        0, 1, CP0_STATUS, 32'h0000ff01, 0, 0, 32'h0, 32'h0,   1, 1);
      vecs[8]  = mkVec(1, 32'h4004, 0, 7'b0100000, 32'h0,        0, 1, CP0_STATUS, 32'h0000ff01, 1, 10, 32'h4004, 32'h0, 0, 0);
      vecs[9]  = mkVec(1, 32'h5000, 0, 7'b0000000, 32'h0,        0, 0, 8'h0, 32'h0,       0, 0,  32'h0,    32'h0,        0, 1);
      vecs[10] = mkVec(0, 32'h6000, 0, 7'b0010000, 32'h0,        0, 0, 8'h0, 32'h0,       0, 0,  32'h0,    32'h0,        0, 0);
      vecs[11] = mkVec(1, 32'h7000, 1, 7'b0001100, 32'h0,        0, 0, 8'h0, 32'h0,       1, 8,  32'h6ffc, 32'h0,        0, 0);
      vecs[12] = mkVec(1, 32'h7004, 0, 7'b0010000, 32'h0,        1, 0, 8'h0, 32'h0,       1, 12, 32'h7004, 32'h0,        0, 0);

      // Reset with busy-looking inputs: every output must still read idle.
      idl = idleIn();
      cur = idleIn();
      cur.valid = 1; cur.exc = 7'b0010000; cur.eret = 1; cur.mtc0 = 1;
      cur.hw = 6'h3f; cur.ie = 1; cur.im = 8'hff; cur.pc = 32'h1234;
      resetn = 1'b0;
      driveInputs(cur);
      #23;
      checkResetOutputs("reset");
      driveInputs(idl);
      modelReset();
      @(negedge clk);
      resetn = 1'b1;
      exp_o = refModel(idl);
      stepClock(idl, exp_o);

      for (int k = 0; k < 13; k++) begin
         string n;
         n = $sformatf("vec%0d", k);
         applyStimulus(vecs[k].in, n, exp_o);
         checkField({n, ".tbl_ex"},     32'(wb_ex),     32'(vecs[k].ex));
         checkField({n, ".tbl_code"},   32'(wb_excode), 32'(vecs[k].code));
         checkField({n, ".tbl_epc"},    wb_epc,         vecs[k].epc);
         checkField({n, ".tbl_badv"},   wb_badvaddr,    vecs[k].badv);
         checkField({n, ".tbl_we"},     32'(mtc0_we),   32'(vecs[k].we));
         checkField({n, ".tbl_commit"}, 32'(ws_commit), 32'(vecs[k].commit));
         stepClock(vecs[k].in, exp_o);
         applyStimulus(idl, {n, "_after"}, exp_o);
         if (vecs[k].ex) begin
            checkField({n, ".next_fv"},  32'(flush_valid), 32'd1);
            checkField({n, ".next_fpc"}, flush_pc,         32'hbfc00380);
         end
         stepClock(idl, exp_o);
      end

      // ERET with fetch stalling three cycles; epc_value moves during FLUSH.
      fv_count = 0;
      eret_count = 0;
      cur = idleIn();
      cur.valid = 1; cur.eret = 1; cur.epc = 32'h2000; cur.ready = 0; cur.pc = 32'h8000;
      applyStimulus(cur, "eret", exp_o);
      checkField("eret.fpc", flush_pc, 32'h2000);
      eret_count += int'(eret_flush);
      stepClock(cur, exp_o);
      for (int c = 0; c < 4; c++) begin
         cur = idleIn();
         cur.valid = 1; cur.eret = (c == 0); cur.epc = 32'h3000;
         cur.ready = (c == 3); cur.pc = 32'h8004 + 32'(c * 4);
         applyStimulus(cur, $sformatf("eret_fl%0d", c), exp_o);
         checkField($sformatf("eret_fl%0d.fpc", c),    flush_pc,        32'h2000);
         checkField($sformatf("eret_fl%0d.commit", c), 32'(ws_commit), 32'd0);
         fv_count   += int'(flush_valid);
         eret_count += int'(eret_flush);
         stepClock(cur, exp_o);
      end
      checkField("eret.pulses",  32'(eret_count), 32'd1);
      checkField("eret.fv_cycles", 32'(fv_count), 32'd4);
      runCycle(idl, "eret_done");

      // Interrupt on hw_int[0] through the synchroniser.
      cur = idleIn();
      cur.ie = 1; cur.exl = 0; cur.im = 8'h04; cur.hw = 6'h01;
      runCycle(cur, "int_c0");
      applyStimulus(cur, "int_c1", exp_o);
      checkField("int_c1.ip0", 32'(cause_ip_hw[0]), 32'd0);
      stepClock(cur, exp_o);
      cur.valid = 1; cur.pc = 32'h9000;
      applyStimulus(cur, "int_c2", exp_o);
      checkField("int_c2.ip0",  32'(cause_ip_hw[0]), 32'd1);
      checkField("int_c2.ex",   32'(wb_ex),          32'd1);
      checkField("int_c2.code", 32'(wb_excode),      32'(EX_INT));
      stepClock(cur, exp_o);
      cur.valid = 0; cur.ready = 1;
      runCycle(cur, "int_drain");
      cur.valid = 1; cur.exl = 1;
      applyStimulus(cur, "int_exl", exp_o);
      checkField("int_exl.ex",     32'(wb_ex),     32'd0);
      checkField("int_exl.commit", 32'(ws_commit), 32'd1);
      stepClock(cur, exp_o);
      runCycle(idl, "int_clr0");
      runCycle(idl, "int_clr1");

      // Asynchronous reset while a redirect is outstanding.
      cur = idleIn();
      cur.valid = 1; cur.exc = 7'b0010000; cur.ready = 0; cur.pc = 32'ha000; cur.hw = 6'h02;
      runCycle(cur, "rst_enter");
      applyStimulus(cur, "rst_flush", exp_o);
      checkField("rst_flush.fv", 32'(flush_valid), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      checkResetOutputs("rst_mid");
      driveInputs(idl);
      modelReset();
      @(negedge clk);
      resetn = 1'b1;
      exp_o = refModel(idl);
      stepClock(idl, exp_o);
      cur = idleIn();
      cur.valid = 1; cur.pc = 32'hb000;
      applyStimulus(cur, "rst_after", exp_o);
      checkField("rst_after.fv",     32'(flush_valid), 32'd0);
      checkField("rst_after.commit", 32'(ws_commit),   32'd1);
      stepClock(cur, exp_o);

      // Randomised traffic against the reference model.
      cur = idleIn();
      for (int n = 0; n < 400; n++) begin
         cur.valid = ($urandom_range(0, 3) != 0);
         cur.pc    = {$urandom_range(0, 65535), 2'b00, 14'($urandom)} ;
         cur.bd    = 1'($urandom);
         cur.exc   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
         cur.badv  = $urandom;
         cur.eret  = ($urandom_range(0, 7) == 0);
         cur.mtc0  = ($urandom_range(0, 3) == 0);
         cur.addr  = addrs[$urandom_range(0, 3)];
         cur.rtv   = $urandom;
         cur.ie    = 1'($urandom);
         cur.exl   = ($urandom_range(0, 3) == 0);
         cur.im    = 8'($urandom);
         cur.ipsw  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
         cur.epc   = $urandom;
         if ($urandom_range(0, 3) == 0) cur.hw = 6'($urandom);
         cur.ready = 1'($urandom);
         runCycle(cur, $sformatf("rnd%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
